fb_fill_engine: RTL and testbench

Hardware rectangle-fill engine for the multi-buffer framebuffer. It accepts fill commands (origin, size, colour, target buffer) and streams one pixel write per cycle into framebuffer port A. Rectangles are clipped to the screen. It also owns the vsync-synchronised front/back buffer swap that selects which buffer the scan-out side reads. It sits between the command source (CPU/AXI register block) and the framebuffer BRAM write port, replacing per-pixel software writes.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_swap_ctrl.sv | 63 ++++++
 rtl/fb_fill_engine.sv | 200 ++++++++++++++++++++
 tb/tb_fb_fill_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fill engine: default geometry,
// fill FSM state encoding and the RGB332 pixel packing helper.
// Ports: none (package).
package fb_pkg;

  localparam int FB_W_DEF = 320;
  localparam int FB_H_DEF = 240;

  // Width of the command coordinate and size fields.
  localparam int CMD_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // Pack 8-bit R, G, B channels into one RGB332 pixel.
  function automatic logic [7:0] rgb332(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Front/back buffer selection, swapped on the vsync rising edge after a request.
// Ports: aclk/arstn; vsync (scan-out sync), swap_req (pulse);
//        swap_pending, front_buf, back_buf (= front_buf+1 mod NUM_BUF).
module fb_swap_ctrl #(
  parameter int NUM_BUF = 2,
  parameter int BUF_W   = 1
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic             vsync,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic [BUF_W-1:0] front_buf,
  output logic [BUF_W-1:0] back_buf
);

  localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUF - 1);

  logic             vsync_q;
  logic             vsync_qq;
  logic             pend_q, pend_d;
  logic [BUF_W-1:0] front_q, front_d;
  logic             vsync_rise;

  function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] b);
    return (b == LAST_BUF) ? '0 : b + 1'b1;
  endfunction

  // Edge detected on the registered copy, so the swap lands two cycles
  // after vsync rises.
  assign vsync_rise = vsync_q & ~vsync_qq;

  always_comb begin
    pend_d  = pend_q;
    front_d = front_q;
    if (vsync_rise && pend_q) begin
      front_d = next_buf(front_q);
      // A request arriving on the applying edge is kept for the next frame.
      pend_d  = swap_req;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      pend_q   <= 1'b0;
      front_q  <= '0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      pend_q   <= pend_d;
      front_q  <= front_d;
    end
  end

  assign swap_pending = pend_q;
  assign front_buf    = front_q;
  assign back_buf     = next_buf(front_q);

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle fill engine: clips a fill command to the screen and streams one
// pixel write per cycle into framebuffer port A, plus vsync buffer swap.
// Ports: aclk/arstn; cmd_* (valid/ready command); busy/done status;
//        fb_wea/fb_addra/fb_dina with fb_wready grant; vsync/swap_req and
//        front_buf/back_buf/swap_pending from the swap controller.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int  FB_W    = FB_W_DEF,
  parameter int  FB_H    = FB_H_DEF,
  parameter int  PIX_W   = 8,
  parameter int  NUM_BUF = 2,
  parameter int  ADDR_W  = 18,
  localparam int BUF_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_x0,
  input  logic [CMD_W-1:0]  cmd_y0,
  input  logic [CMD_W-1:0]  cmd_w,
  input  logic [CMD_W-1:0]  cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  input  logic [BUF_W-1:0]  cmd_buf,
  output logic              busy,
  output logic              done,
  output logic              fb_wea,
  output logic [ADDR_W-1:0] fb_addra,
  output logic [PIX_W-1:0]  fb_dina,
  input  logic              fb_wready,
  input  logic              vsync,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic [BUF_W-1:0]  front_buf,
  output logic [BUF_W-1:0]  back_buf
);

  localparam int              XW       = CMD_W + 1;
  localparam logic [XW-1:0]   FB_W_X   = XW'(FB_W);
  localparam logic [XW-1:0]   FB_H_X   = XW'(FB_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] BUF_SIZE = ADDR_W'(FB_W * FB_H);

  fill_state_e state_q, state_d;

  // Latched command.
  logic [CMD_W-1:0]  x0_q, y0_q, w_q, h_q;
  logic [PIX_W-1:0]  color_q;
  logic [BUF_W-1:0]  buf_q;

  // Clipped exclusive end coordinates and raster position.
  logic [XW-1:0]     x1_q, y1_q;
  logic [CMD_W-1:0]  x_q, y_q;
  logic [ADDR_W-1:0] row_q;   // address of (0, y_q) in the target buffer
  logic [ADDR_W-1:0] addr_q;

  logic [XW-1:0]     x_end_c, y_end_c, x1_c, y1_c;
  logic              empty_c;
  logic [ADDR_W-1:0] row_base_c;
  logic [XW-1:0]     x_nxt_c, y_nxt_c;
  logic              last_x_c, last_y_c;
  logic              wr_acc_c;

  // ---------------------------------------------------------------------
  // Clip arithmetic (used in CLIP only)
  // ---------------------------------------------------------------------
  assign x_end_c = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end_c = {1'b0, y0_q} + {1'b0, h_q};
  assign x1_c    = (x_end_c > FB_W_X) ? FB_W_X : x_end_c;
  assign y1_c    = (y_end_c > FB_H_X) ? FB_H_X : y_end_c;
  assign empty_c = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= FB_W_X) || ({1'b0, y0_q} >= FB_H_X);

  // The single multiply: start-of-row address for the first row.
  assign row_base_c = ADDR_W'(buf_q) * BUF_SIZE + ADDR_W'(y0_q) * ROW_STEP;

  // ---------------------------------------------------------------------
  // Raster stepping (used in FILL)
  // ---------------------------------------------------------------------
  assign x_nxt_c  = {1'b0, x_q} + 1'b1;
  assign y_nxt_c  = {1'b0, y_q} + 1'b1;
  assign last_x_c = (x_nxt_c == x1_q);
  assign last_y_c = (y_nxt_c == y1_q);
  assign wr_acc_c = (state_q == FILL) && fb_wready;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    fb_wea    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = CLIP;
      end
      CLIP: begin
        state_d = empty_c ? DONE : FILL;
      end
      FILL: begin
        fb_wea = 1'b1;
        if (wr_acc_c && last_x_c && last_y_c) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      buf_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            x0_q    <= cmd_x0;
            y0_q    <= cmd_y0;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            buf_q   <= cmd_buf;
          end
        end
        CLIP: begin
          x1_q   <= x1_c;
          y1_q   <= y1_c;
          x_q    <= x0_q;
          y_q    <= y0_q;
          row_q  <= row_base_c;
          addr_q <= row_base_c + ADDR_W'(x0_q);
        end
        FILL: begin
          // Address/data hold while the arbiter withholds the grant.
          if (wr_acc_c) begin
            if (last_x_c) begin
              x_q    <= x0_q;
              y_q    <= y_nxt_c[CMD_W-1:0];
              row_q  <= row_q + ROW_STEP;
              addr_q <= row_q + ROW_STEP + ADDR_W'(x0_q);
            end else begin
              x_q    <= x_nxt_c[CMD_W-1:0];
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fb_addra = addr_q;
  assign fb_dina  = color_q;

  // ---------------------------------------------------------------------
  // Buffer swap, independent of the fill FSM
  // ---------------------------------------------------------------------
  fb_swap_ctrl #(
    .NUM_BUF (NUM_BUF),
    .BUF_W   (BUF_W)
  ) u_swap (
    .aclk         (aclk),
    .arstn        (arstn),
    .vsync        (vsync),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_buf    (front_buf),
    .back_buf     (back_buf)
  );

endmodule

// File: tb/tb_fb_fill_engine.sv
module tb_fb_fill_engine;
  import fb_pkg::*;

  localparam int W  = 320;
  localparam int H  = 240;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [0:0]  cmd_buf = '0;
  logic        busy, done, fb_wea;
  logic [17:0] fb_addra;
  logic [7:0]  fb_dina;
  logic        fb_wready = 1'b1;
  logic        vsync = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic [0:0]  front_buf, back_buf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int wr_mode = 0;          // 0: always granted, 1: alternate, 2: random

  int         exp_addr_q[$];
  logic [7:0] exp_dat_q[$];

  fb_fill_engine dut (
    .aclk(aclk), .arstn(arstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .cmd_buf(cmd_buf),
    .busy(busy), .done(done),
    .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina), .fb_wready(fb_wready),
    .vsync(vsync), .swap_req(swap_req), .swap_pending(swap_pending),
    .front_buf(front_buf), .back_buf(back_buf)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the clipped rectangle as a list of pixel writes.
  function automatic int model_push(input int x0, input int y0, input int w, input int h,
                                    input logic [7:0] col, input int b);
    int x1, y1, n;
    n = 0;
    if (w == 0 || h == 0 || x0 >= W || y0 >= H) return 0;
    x1 = (x0 + w > W) ? W : x0 + w;
    y1 = (y0 + h > H) ? H : y0 + h;
    for (int y = y0; y < y1; y++)
      for (int x = x0; x < x1; x++) begin
        exp_addr_q.push_back(b * W * H + y * W + x);
        exp_dat_q.push_back(col);
        n++;
      end
    return n;
  endfunction

  // Grant pattern driver.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (wr_mode)
        0:       fb_wready = 1'b1;
        1:       fb_wready = ~fb_wready;
        default: fb_wready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every write request is compared with the head of the expected
  // stream; the head is consumed only when the write is granted, so a stall
  // that moves address or data is caught too.
  initial begin
    forever begin
      @(negedge aclk);
      if (arstn && fb_wea) begin
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", fb_addra);
        end else begin
          check("wr_addr", fb_addra, exp_addr_q[0]);
          check("wr_data", fb_dina, exp_dat_q[0]);
          if (fb_wready) begin
            void'(exp_addr_q.pop_front());
            void'(exp_dat_q.pop_front());
            last_acc_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic issue_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [7:0] col, input int b,
                           output int t_acc, output int n);
    bit ok;
    n = model_push(x0, y0, w, h, col, b);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b1;
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = col;  cmd_buf = 1'(b);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    t_acc = cyc;
    check("cmd_accept", ok, 1);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input logic [7:0] col, input int b, input int budget);
    int t_acc, n, t_done;
    bit got;
    issue_cmd(x0, y0, w, h, col, b, t_acc, n);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge aclk);
      if (done) begin got = 1'b1; break; end
    end
    t_done = cyc;
    check("done_seen", got, 1);
    if (got) begin
      check("writes_outstanding", exp_addr_q.size(), 0);
      if (n == 0) begin
        check("empty_done_cycle", t_done - t_acc, 2);
      end else begin
        check("done_after_last_write", t_done - last_acc_cyc, 1);
        if (wr_mode == 0) check("done_latency", t_done - t_acc, n + 2);
      end
      check("cmd_ready_in_done", cmd_ready, 0);
      @(negedge aclk);
      check("done_one_cycle", done, 0);
      check("cmd_ready_after_done", cmd_ready, 1);
    end
    exp_addr_q.delete();
    exp_dat_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fb_wea"}, fb_wea, 0);
    check({tag, "_fb_addra"}, fb_addra, 0);
    check({tag, "_fb_dina"}, fb_dina, 0);
    check({tag, "_swap_pending"}, swap_pending, 0);
    check({tag, "_front_buf"}, front_buf, 0);
    check({tag, "_back_buf"}, back_buf, 1);
  endtask

  initial begin
    int t_acc, n;

    // Reset state
    repeat (2) @(negedge aclk);
    check_reset_values("rst");
    @(posedge aclk);
    #1 arstn = 1'b1;

    // Full clear, buffer 0
    wr_mode = 0;
    run_cmd(0, 0, 320, 240, 8'h01, 0, 80000);

    // Plain rectangle into buffer 1
    run_cmd(10, 10, 50, 30, rgb332(8'hFF, 8'h00, 8'h00), 1, 3000);

    // Clipped at bottom-right corner
    run_cmd(300, 230, 50, 30, 8'h3C, 0, 1000);

    // Degenerate commands
    run_cmd(5, 5, 0, 10, 8'h11, 0, 20);
    run_cmd(320, 5, 10, 10, 8'h22, 1, 20);
    run_cmd(5, 240, 10, 10, 8'h33, 0, 20);
    run_cmd(5, 5, 10, 0, 8'h44, 1, 20);

    // Alternating grant
    wr_mode = 1;
    run_cmd(5, 5, 7, 4, 8'h77, 1, 500);

    // Random rectangles under random grant
    wr_mode = 2;
    for (int i = 0; i < 12; i++)
      run_cmd($urandom_range(0, 330), $urandom_range(0, 245),
              $urandom_range(0, 25), $urandom_range(0, 25),
              8'($urandom), $urandom_range(0, 1), 5000);

    // Swap during a fill into buffer 0
    wr_mode = 0;
    fork
      run_cmd(20, 20, 30, 20, 8'hA5, 0, 2000);
      begin
        repeat (5) @(posedge aclk);
        #1 swap_req = 1'b1;
        @(posedge aclk);
        #1 swap_req = 1'b0;
        @(negedge aclk);
        check("swap_pending_set", swap_pending, 1);
        check("front_before", front_buf, 0);
        @(posedge aclk);
        #1 vsync = 1'b1;
        @(negedge aclk);
        check("front_vsync_c0", front_buf, 0);
        @(posedge aclk);
        #1 swap_req = 1'b1;   // coincides with the applying edge
        @(negedge aclk);
        check("front_vsync_c1", front_buf, 0);
        check("busy_during_swap", busy, 1);
        @(posedge aclk);
        #1 swap_req = 1'b0;
        @(negedge aclk);
        check("front_vsync_c2", front_buf, 1);
        check("back_after_swap", back_buf, 0);
        check("pending_rerequested", swap_pending, 1);
        repeat (3) @(posedge aclk);
        #1 vsync = 1'b0;
        repeat (4) @(negedge aclk);
        check("front_stays", front_buf, 1);
      end
    join

    // Asynchronous reset mid-fill
    wr_mode = 2;
    issue_cmd(0, 0, 40, 40, 8'h5A, 1, t_acc, n);
    repeat (30) @(posedge aclk);
    #1 check("busy_before_rst", busy, 1);
    #1 arstn = 1'b0;
    #1 check_reset_values("midfill_rst");
    exp_addr_q.delete();
    exp_dat_q.delete();
    repeat (2) @(posedge aclk);
    #1 arstn = 1'b1;

    // Recovery after reset
    wr_mode = 1;
    run_cmd(100, 50, 9, 3, 8'hC3, 0, 500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
